// File: rtl/pmbist_resp_analyzer.sv
// PMBIST response analyzer: delays expected data/address to line up with the
// memory read latency, compares against read-back data and keeps fail results.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module pmbist_resp_analyzer #(
  parameter int dw     = `DATA_WIDTH,
  parameter int aw     = 8,
  parameter int cw     = 8,
  parameter int rd_lat = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clear,
  input  logic          cmp_vld,
  input  logic [dw-1:0] exp_data,
  input  logic [aw-1:0] addr,
  input  logic [dw-1:0] rd_data,
  output logic          fail_now,
  output logic          fail,
  output logic [cw-1:0] fail_cnt,
  output logic [aw-1:0] ff_addr,
  output logic [dw-1:0] ff_syn,
  output logic          busy
);

  if (rd_lat < 1 || rd_lat > 4) begin : g_lat_chk
    $error("pmbist_resp_analyzer: rd_lat=%0d outside legal range 1..4", rd_lat);
  end

  logic [rd_lat:1]         vld_pipe_q, vld_pipe_d;
  logic [rd_lat:1][dw-1:0] exp_pipe_q, exp_pipe_d;
  logic [rd_lat:1][aw-1:0] adr_pipe_q, adr_pipe_d;

  logic          cmp_v_q, cmp_v_d;
  logic [dw-1:0] syn_q, syn_d;
  logic [aw-1:0] cmp_adr_q, cmp_adr_d;

  logic          fail_now_q, fail_now_d;
  logic          fail_q, fail_d;
  logic [cw-1:0] fail_cnt_q, fail_cnt_d;
  logic [aw-1:0] ff_addr_q, ff_addr_d;
  logic [dw-1:0] ff_syn_q, ff_syn_d;
  logic          mis;

  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    exp_pipe_d    = exp_pipe_q;
    adr_pipe_d    = adr_pipe_q;
    vld_pipe_d[1] = cmp_vld & en & ~clear;
    exp_pipe_d[1] = exp_data;
    adr_pipe_d[1] = addr;
    for (int k = 2; k <= rd_lat; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1] & ~clear;
      exp_pipe_d[k] = exp_pipe_q[k-1];
      adr_pipe_d[k] = adr_pipe_q[k-1];
    end

    // rd_data only enters the syndrome when a real strobe sits at the last stage,
    // so unknown bus values between reads never reach the result registers.
    cmp_v_d   = vld_pipe_q[rd_lat] & ~clear;
    syn_d     = vld_pipe_q[rd_lat] ? (exp_pipe_q[rd_lat] ^ rd_data) : '0;
    cmp_adr_d = adr_pipe_q[rd_lat];

    mis        = cmp_v_q & (syn_q != '0);
    fail_now_d = mis;
    fail_d     = fail_q | mis;
    fail_cnt_d = fail_cnt_q;
    ff_addr_d  = ff_addr_q;
    ff_syn_d   = ff_syn_q;
    if (mis && fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
    if (mis && !fail_q) begin
      ff_addr_d = cmp_adr_q;
      ff_syn_d  = syn_q;
    end

    if (clear) begin
      fail_now_d = 1'b0;
      fail_d     = 1'b0;
      fail_cnt_d = '0;
      ff_addr_d  = '0;
      ff_syn_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q <= '0;
      exp_pipe_q <= '0;
      adr_pipe_q <= '0;
      cmp_v_q    <= 1'b0;
      syn_q      <= '0;
      cmp_adr_q  <= '0;
      fail_now_q <= 1'b0;
      fail_q     <= 1'b0;
      fail_cnt_q <= '0;
      ff_addr_q  <= '0;
      ff_syn_q   <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      exp_pipe_q <= exp_pipe_d;
      adr_pipe_q <= adr_pipe_d;
      cmp_v_q    <= cmp_v_d;
      syn_q      <= syn_d;
      cmp_adr_q  <= cmp_adr_d;
      fail_now_q <= fail_now_d;
      fail_q     <= fail_d;
      fail_cnt_q <= fail_cnt_d;
      ff_addr_q  <= ff_addr_d;
      ff_syn_q   <= ff_syn_d;
    end
  end

  assign fail_now = fail_now_q;
  assign fail     = fail_q;
  assign fail_cnt = fail_cnt_q;
  assign ff_addr  = ff_addr_q;
  assign ff_syn   = ff_syn_q;
  assign busy     = (|vld_pipe_q) | cmp_v_q;

endmodule
